reg_dump_unit: RTL



---
 rtl/reg_dump_pkg.sv | 11 +
 rtl/reg_dump_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/reg_dump_pkg.sv
// Types shared by the register-dump unit: the dump sequencer's state encoding.
package reg_dump_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        FIN
    } dump_state_t;

endpackage

// File: rtl/reg_dump_unit.sv
// Walks every register address through a combinational read port and streams the
// values out over valid/ready with address and last tags, summing them into a checksum.
module reg_dump_unit
    import reg_dump_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    output logic [D-1:0] RaddrOut,
    input  logic [W-1:0] RdataIn,
    output logic [W-1:0] OutData,
    output logic [D-1:0] OutAddr,
    output logic         OutLast,
    output logic         OutValid,
    input  logic         OutReady,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Checksum
);

    localparam logic [D-1:0] LAST_ADDR = '1;

    dump_state_t  state;
    dump_state_t  next_state;
    logic [D-1:0] addr;
    logic         handshake;

    assign handshake = OutValid && OutReady;

    // The walk pointer only moves at Start and at accepted handshakes, so it already
    // holds its value outside FETCH and can drive the read port directly.
    assign RaddrOut = addr;
    assign Busy     = (state != IDLE);
    assign Done     = (state == FIN);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (Start) next_state = FETCH;
            FETCH:   next_state = SEND;
            SEND:    if (handshake) next_state = OutLast ? FIN : FETCH;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr     <= '0;
            OutData  <= '0;
            OutAddr  <= '0;
            OutLast  <= 1'b0;
            OutValid <= 1'b0;
            Checksum <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        addr     <= '0;
                        Checksum <= '0;
                    end
                end
                FETCH: begin
                    OutData  <= RdataIn;
                    OutAddr  <= addr;
                    OutLast  <= (addr == LAST_ADDR);
                    OutValid <= 1'b1;
                end
                SEND: begin
                    if (handshake) begin
                        OutValid <= 1'b0;
                        Checksum <= Checksum + OutData;
                        // The last word exits to FIN, so the pointer never wraps.
                        if (!OutLast) addr <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
